// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60), axis phase enumeration and test-pattern palette.
package vga_timing_pkg;

  localparam int unsigned CNT_W     = 12;
  localparam int unsigned RGB_W     = 16;
  localparam int unsigned MAX_TOTAL = 4096;

  localparam int unsigned H_SIZE = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SW   = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned V_SIZE = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SW   = 2;
  localparam int unsigned V_BP   = 33;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  // RGB565 colour of each of the eight vertical test bars, left to right
  function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing output bundle; RGB exists only when VGA_SYNC_GEN_TESTPAT_EN is defined.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             Hsync;
  logic             Vsync;
  logic             DE;
  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;
  logic             frame_start;
`ifdef VGA_SYNC_GEN_TESTPAT_EN
  logic [RGB_W-1:0] RGB;

  modport master (output Hsync, Vsync, DE, hpos, vpos, frame_start, RGB);
  modport slave  (input  Hsync, Vsync, DE, hpos, vpos, frame_start, RGB);
`else
  modport master (output Hsync, Vsync, DE, hpos, vpos, frame_start);
  modport slave  (input  Hsync, Vsync, DE, hpos, vpos, frame_start);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with wrap pulse and ACTIVE/FRONT/SYNC/BACK decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned SIZE = H_SIZE,
  parameter int unsigned FP   = H_FP,
  parameter int unsigned SW   = H_SW,
  parameter int unsigned BP   = H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap_c,
  output phase_e           phase_c
);

  localparam int unsigned      TOTAL = SIZE + FP + SW + BP;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Advance on enable, wrapping from LAST back to zero
  always_comb begin
    wrap_c = en && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (en) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Phase boundaries compared at full integer width so a 4096 total cannot alias
  always_comb begin
    phase_c = BACK;
    if (32'(cnt_q) < SIZE) begin
      phase_c = ACTIVE;
    end else if (32'(cnt_q) < SIZE + FP) begin
      phase_c = FRONT;
    end else if (32'(cnt_q) < SIZE + FP + SW) begin
      phase_c = SYNC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/DE/position generator with registered outputs lagging the counters by one CE.
// Define VGA_SYNC_GEN_TESTPAT_EN to add an RGB565 eight-colour-bar test pattern output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned HSIZE = H_SIZE,
  parameter int unsigned HFP   = H_FP,
  parameter int unsigned HSW   = H_SW,
  parameter int unsigned HBP   = H_BP,
  parameter int unsigned VSIZE = V_SIZE,
  parameter int unsigned VFP   = V_FP,
  parameter int unsigned VSW   = V_SW,
  parameter int unsigned VBP   = V_BP
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           CE,
  vga_sync_gen_if.master vga
);

  localparam int unsigned HTOTAL = HSIZE + HFP + HSW + HBP;
  localparam int unsigned VTOTAL = VSIZE + VFP + VSW + VBP;

  if (HTOTAL > MAX_TOTAL) begin : g_bad_htotal
    $error("vga_sync_gen: HTOTAL %0d does not fit the 12-bit counter", HTOTAL);
  end
  if (VTOTAL > MAX_TOTAL) begin : g_bad_vtotal
    $error("vga_sync_gen: VTOTAL %0d does not fit the 12-bit counter", VTOTAL);
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap_c, v_wrap_unused_c;
  phase_e           h_phase_c, v_phase_c;

  vga_axis_counter #(.SIZE(HSIZE), .FP(HFP), .SW(HSW), .BP(HBP)) u_h_axis (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .en      (CE),
    .cnt     (h_cnt),
    .wrap_c  (h_wrap_c),
    .phase_c (h_phase_c)
  );

  // Vertical axis steps once per completed line
  vga_axis_counter #(.SIZE(VSIZE), .FP(VFP), .SW(VSW), .BP(VBP)) u_v_axis (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .en      (h_wrap_c),
    .cnt     (v_cnt),
    .wrap_c  (v_wrap_unused_c),
    .phase_c (v_phase_c)
  );

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [CNT_W-1:0] hpos_q, hpos_d;
  logic [CNT_W-1:0] vpos_q, vpos_d;
  logic             frame_start_q, frame_start_d;

`ifdef VGA_SYNC_GEN_TESTPAT_EN
  localparam int unsigned BAR_W = (HSIZE / 8 == 0) ? 1 : HSIZE / 8;

  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [CNT_W-1:0] bar_col_c;
  logic [2:0]       bar_idx_c;

  // Columns past the eighth full bar (HSIZE not a multiple of 8) stay in the last bar
  always_comb begin
    bar_col_c = h_cnt / CNT_W'(BAR_W);
    bar_idx_c = (bar_col_c > CNT_W'(7)) ? 3'd7 : bar_col_c[2:0];
  end
`endif

  // Outputs sample the pre-increment counters on CE and hold otherwise
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_start_d = frame_start_q;
`ifdef VGA_SYNC_GEN_TESTPAT_EN
    rgb_d         = rgb_q;
`endif
    if (CE) begin
      de_d          = (h_phase_c == ACTIVE) && (v_phase_c == ACTIVE);
      hsync_d       = (h_phase_c != SYNC);
      vsync_d       = (v_phase_c != SYNC);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      if (de_d) begin
        hpos_d = h_cnt;
        vpos_d = v_cnt;
      end
`ifdef VGA_SYNC_GEN_TESTPAT_EN
      rgb_d = de_d ? bar_colour(bar_idx_c) : '0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_start_q <= 1'b0;
`ifdef VGA_SYNC_GEN_TESTPAT_EN
      rgb_q         <= '0;
`endif
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_SYNC_GEN_TESTPAT_EN
      rgb_q         <= rgb_d;
`endif
    end
  end

  assign vga.Hsync       = hsync_q;
  assign vga.Vsync       = vsync_q;
  assign vga.DE          = de_q;
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.frame_start = frame_start_q;
`ifdef VGA_SYNC_GEN_TESTPAT_EN
  assign vga.RGB         = rgb_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: two generators (full-width lines / tiny 8x4 raster) against an arithmetic raster model.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

`ifdef VGA_SYNC_GEN_TESTPAT_EN
  localparam int OW = 44;
`else
  localparam int OW = 28;
`endif
  typedef logic [OW-1:0] ovec_t;

  localparam int unsigned A_HS = 640, A_HFP = 16, A_HSW = 96, A_HBP = 48;
  localparam int unsigned A_VS = 6,   A_VFP = 2,  A_VSW = 2,  A_VBP = 3;
  localparam int unsigned A_HT = 800, A_VT = 13;
  localparam int unsigned B_HS = 8,   B_HFP = 1,  B_HSW = 1,  B_HBP = 1;
  localparam int unsigned B_VS = 4,   B_VFP = 1,  B_VSW = 1,  B_VBP = 1;
  localparam int unsigned B_HT = 11,  B_VT = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  int unsigned k;
  int compared;
  int mismatched;

  always #5 clk = ~clk;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();

  vga_sync_gen #(.HSIZE(A_HS), .HFP(A_HFP), .HSW(A_HSW), .HBP(A_HBP),
                 .VSIZE(A_VS), .VFP(A_VFP), .VSW(A_VSW), .VBP(A_VBP)) u_dut_a (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .vga(if_a)
  );

  vga_sync_gen #(.HSIZE(B_HS), .HFP(B_HFP), .HSW(B_HSW), .HBP(B_HBP),
                 .VSIZE(B_VS), .VFP(B_VFP), .VSW(B_VSW), .VBP(B_VBP)) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .vga(if_b)
  );

`ifdef VGA_SYNC_GEN_TESTPAT_EN
  function automatic logic [15:0] tb_colour(input int unsigned idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction
`endif

  // Expected outputs after kk enabled edges since reset: the raster position seen is kk-1
  function automatic ovec_t model(input int unsigned kk, hs, hfp, hsw, hbp, vs, vfp, vsw, vbp);
    int unsigned ht, vt, p, h, v, hp, vp;
    logic de, hsn, vsn, fs;
`ifdef VGA_SYNC_GEN_TESTPAT_EN
    int unsigned bw, idx;
    logic [15:0] rgb;
    rgb = 16'h0;
`endif
    ht = hs + hfp + hsw + hbp;
    vt = vs + vfp + vsw + vbp;
    if (kk == 0) begin
      hsn = 1'b1; vsn = 1'b1; de = 1'b0; hp = 0; vp = 0; fs = 1'b0;
    end else begin
      p   = (kk - 1) % (ht * vt);
      h   = p % ht;
      v   = p / ht;
      de  = (h < hs) && (v < vs);
      hsn = !((h >= hs + hfp) && (h < hs + hfp + hsw));
      vsn = !((v >= vs + vfp) && (v < vs + vfp + vsw));
      hp  = (v < vs && h < hs) ? h : hs - 1;
      vp  = (v < vs) ? v : vs - 1;
      fs  = (p == 0);
`ifdef VGA_SYNC_GEN_TESTPAT_EN
      bw  = (hs / 8 == 0) ? 1 : hs / 8;
      idx = h / bw;
      if (idx > 7) idx = 7;
      rgb = de ? tb_colour(idx) : 16'h0;
`endif
    end
`ifdef VGA_SYNC_GEN_TESTPAT_EN
    return {hsn, vsn, de, 12'(hp), 12'(vp), fs, rgb};
`else
    return {hsn, vsn, de, 12'(hp), 12'(vp), fs};
`endif
  endfunction

  function automatic ovec_t exp_a();
    return model(k, A_HS, A_HFP, A_HSW, A_HBP, A_VS, A_VFP, A_VSW, A_VBP);
  endfunction

  function automatic ovec_t exp_b();
    return model(k, B_HS, B_HFP, B_HSW, B_HBP, B_VS, B_VFP, B_VSW, B_VBP);
  endfunction

  function automatic ovec_t obs_a();
`ifdef VGA_SYNC_GEN_TESTPAT_EN
    return {if_a.Hsync, if_a.Vsync, if_a.DE, if_a.hpos, if_a.vpos, if_a.frame_start, if_a.RGB};
`else
    return {if_a.Hsync, if_a.Vsync, if_a.DE, if_a.hpos, if_a.vpos, if_a.frame_start};
`endif
  endfunction

  function automatic ovec_t obs_b();
`ifdef VGA_SYNC_GEN_TESTPAT_EN
    return {if_b.Hsync, if_b.Vsync, if_b.DE, if_b.hpos, if_b.vpos, if_b.frame_start, if_b.RGB};
`else
    return {if_b.Hsync, if_b.Vsync, if_b.DE, if_b.hpos, if_b.vpos, if_b.frame_start};
`endif
  endfunction

  // One clock with the given CE; returns at the following falling edge
  task automatic tick(input logic ce_v);
    ce = ce_v;
    @(posedge clk);
    if (ce_v && rst_n === 1'b1) k++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      if (obs_a() !== exp_a()) begin mismatched++; $display("FAIL reset_a got %h exp %h", obs_a(), exp_a()); end
      compared++;
      if (obs_b() !== exp_b()) begin mismatched++; $display("FAIL reset_b got %h exp %h", obs_b(), exp_b()); end
      compared++;
    end
  endtask

  task automatic test_line_timing();
    int de_cnt, hs_first, hs_cnt;
    de_cnt = 0; hs_first = -1; hs_cnt = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 1800; i++) begin
      tick(1'b1);
      if (obs_a() !== exp_a()) begin mismatched++; $display("FAIL line_a k=%0d got %h exp %h", k, obs_a(), exp_a()); end
      compared++;
      if (obs_b() !== exp_b()) begin mismatched++; $display("FAIL line_b k=%0d got %h exp %h", k, obs_b(), exp_b()); end
      compared++;
      if (k <= A_HT) begin
        if (if_a.DE === 1'b1) de_cnt++;
        if (if_a.Hsync === 1'b0) begin
          if (hs_first < 0) hs_first = int'(k) - 1;
          hs_cnt++;
        end
      end
    end
    if (de_cnt != 640) begin mismatched++; $display("FAIL de_count got %0d exp 640", de_cnt); end
    compared++;
    if (hs_first != 656) begin mismatched++; $display("FAIL hsync_start got %0d exp 656", hs_first); end
    compared++;
    if (hs_cnt != 96) begin mismatched++; $display("FAIL hsync_width got %0d exp 96", hs_cnt); end
    compared++;
  endtask

  task automatic test_frame();
    int unsigned last_a, last_b;
    int vlo_a, vlo_b, n_int_a, n_int_b;
    last_a = 0; last_b = 0; vlo_a = 0; vlo_b = 0; n_int_a = 0; n_int_b = 0;
    for (int i = 0; i < 21000; i++) begin
      tick(1'b1);
      if (obs_a() !== exp_a()) begin mismatched++; $display("FAIL frame_a k=%0d got %h exp %h", k, obs_a(), exp_a()); end
      compared++;
      if (obs_b() !== exp_b()) begin mismatched++; $display("FAIL frame_b k=%0d got %h exp %h", k, obs_b(), exp_b()); end
      compared++;
      if (if_a.frame_start === 1'b1) begin
        if (last_a != 0) begin
          n_int_a++;
          if (k - last_a != A_HT * A_VT) begin mismatched++; $display("FAIL period_a got %0d exp %0d", k - last_a, A_HT * A_VT); end
          compared++;
          if (vlo_a != 1600) begin mismatched++; $display("FAIL vsync_len_a got %0d exp 1600", vlo_a); end
          compared++;
        end
        last_a = k; vlo_a = 0;
      end
      if (if_b.frame_start === 1'b1) begin
        if (last_b != 0) begin
          n_int_b++;
          if (k - last_b != B_HT * B_VT) begin mismatched++; $display("FAIL period_b got %0d exp %0d", k - last_b, B_HT * B_VT); end
          compared++;
          if (vlo_b != 11) begin mismatched++; $display("FAIL vsync_len_b got %0d exp 11", vlo_b); end
          compared++;
        end
        last_b = k; vlo_b = 0;
      end
      if (if_a.Vsync === 1'b0) vlo_a++;
      if (if_b.Vsync === 1'b0) vlo_b++;
    end
    if (n_int_a < 1) begin mismatched++; $display("FAIL frame_seen_a got %0d exp >=1", n_int_a); end
    compared++;
    if (n_int_b < 200) begin mismatched++; $display("FAIL frame_seen_b got %0d exp >=200", n_int_b); end
    compared++;
  endtask

  task automatic test_ce_random();
    ovec_t pa, pb;
    logic c;
    for (int i = 0; i < 600; i++) begin
      pa = obs_a(); pb = obs_b();
      c = 1'($urandom_range(0, 1));
      tick(c);
      if (obs_a() !== exp_a()) begin mismatched++; $display("FAIL cernd_a k=%0d got %h exp %h", k, obs_a(), exp_a()); end
      compared++;
      if (obs_b() !== exp_b()) begin mismatched++; $display("FAIL cernd_b k=%0d got %h exp %h", k, obs_b(), exp_b()); end
      compared++;
      if (!c) begin
        if (obs_b() !== pb) begin mismatched++; $display("FAIL hold_b got %h exp %h", obs_b(), pb); end
        compared++;
        if (obs_a() !== pa) begin mismatched++; $display("FAIL hold_a got %h exp %h", obs_a(), pa); end
        compared++;
      end
    end
  endtask

  task automatic test_ce_toggle();
    int last_rise, n_int;
    logic prev_fs;
    last_rise = -1; n_int = 0; prev_fs = if_b.frame_start;
    for (int i = 0; i < 500; i++) begin
      tick(1'((i + 1) % 2));
      if (obs_b() !== exp_b()) begin mismatched++; $display("FAIL toggle_b k=%0d got %h exp %h", k, obs_b(), exp_b()); end
      compared++;
      if (if_b.frame_start === 1'b1 && prev_fs === 1'b0) begin
        if (last_rise >= 0) begin
          n_int++;
          if (i - last_rise != 2 * 77) begin mismatched++; $display("FAIL toggle_period got %0d exp 154", i - last_rise); end
          compared++;
        end
        last_rise = i;
      end
      prev_fs = if_b.frame_start;
    end
    if (n_int < 2) begin mismatched++; $display("FAIL toggle_seen got %0d exp >=2", n_int); end
    compared++;
  endtask

  task automatic test_reset_mid();
    int unsigned col;
    rst_n = 1'b0; tick(1'b1); rst_n = 1'b1; k = 0;
    col = $urandom_range(1, A_HT - 1);
    for (int unsigned i = 0; i <= 5 * A_HT + col; i++) tick(1'b1);
    if (obs_a() !== exp_a()) begin mismatched++; $display("FAIL premid_a k=%0d got %h exp %h", k, obs_a(), exp_a()); end
    compared++;
    #2 rst_n = 1'b0;
    #1 k = 0;
    if (obs_a() !== exp_a()) begin mismatched++; $display("FAIL async_rst_a got %h exp %h", obs_a(), exp_a()); end
    compared++;
    if (obs_b() !== exp_b()) begin mismatched++; $display("FAIL async_rst_b got %h exp %h", obs_b(), exp_b()); end
    compared++;
    tick(1'b1); tick(1'b1);
    rst_n = 1'b1;
    tick(1'b1);
    if (if_a.frame_start !== 1'b1 || if_a.DE !== 1'b1) begin
      mismatched++; $display("FAIL post_rst_fs got fs=%b de=%b exp fs=1 de=1", if_a.frame_start, if_a.DE);
    end
    compared++;
    if (obs_a() !== exp_a()) begin mismatched++; $display("FAIL post_rst_a got %h exp %h", obs_a(), exp_a()); end
    compared++;
  endtask

  task automatic test_tiny();
    rst_n = 1'b0; tick(1'b0); rst_n = 1'b1; k = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1'b1);
      if (obs_b() !== exp_b()) begin mismatched++; $display("FAIL tiny_b k=%0d got %h exp %h", k, obs_b(), exp_b()); end
      compared++;
      if (i < 8) begin
        if (if_b.DE !== 1'b1 || if_b.hpos !== 12'(i)) begin
          mismatched++; $display("FAIL tiny_hpos got de=%b hpos=%0d exp de=1 hpos=%0d", if_b.DE, if_b.hpos, i);
        end
        compared++;
      end
      if (i == 9) begin
        if (if_b.Hsync !== 1'b0) begin mismatched++; $display("FAIL tiny_hsync got %b exp 0", if_b.Hsync); end
        compared++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    compared = 0; mismatched = 0; k = 0;
    rst_n = 1'b0; ce = 1'b0;
    @(negedge clk);
    test_reset();
    test_line_timing();
    test_frame();
    test_ce_random();
    test_ce_toggle();
    test_reset_mid();
    test_tiny();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter HSIZE, default 640, active pixels per line SHALL be set by this parameter.
REQ-002 Parameter HFP, default 16, horizontal front porch in pixels.
REQ-003 Parameter HSW, default 96, horizontal sync width in pixels.
REQ-004 Parameter HBP, default 48, horizontal back porch in pixels.
REQ-005 Parameter VSIZE, default 480, active lines per frame.
REQ-006 Parameter VFP, default 10; VSW, default 2; VBP, default 33: vertical porch and sync widths in lines.
REQ-007 CLK  in  1  single clock; all state SHALL be clocked on its rising edge.
REQ-008 RESET_N  in  1  asynchronous, active-low reset.
REQ-009 CE  in  1  pixel enable; timing state SHALL advance only on edges where CE=1.
REQ-010 Hsync  out  1  horizontal sync, active-low.
REQ-011 Vsync  out  1  vertical sync, active-low.
REQ-012 DE  out  1  high during active pixels only.
REQ-013 hpos  out  12  active pixel column, 0..HSIZE-1.
REQ-014 vpos  out  12  active line, 0..VSIZE-1.
REQ-015 frame_start  out  1  one-CE pulse on the first active pixel of each frame (hpos=0, vpos=0, DE=1).

Function
REQ-016 HTOTAL=HSIZE+HFP+HSW+HBP (800) and VTOTAL=VSIZE+VFP+VSW+VBP (525) SHALL be derived at elaboration.
REQ-017 Internal hcnt SHALL count 0..HTOTAL-1 on CE and wrap to 0; vcnt SHALL increment on hcnt wrap and wrap from VTOTAL-1 to 0.
REQ-018 Horizontal phases in order: ACTIVE (hcnt<HSIZE), FRONT, SYNC (HSIZE+HFP <= hcnt < HSIZE+HFP+HSW), BACK; vertical phases identical on vcnt.
REQ-019 All outputs SHALL be registered, loaded on CE from the pre-increment counter values; outputs lag counters by exactly one CE.
REQ-020 DE=1 iff hcnt<HSIZE and vcnt<VSIZE; hpos/vpos SHALL hold their last active value while DE=0.
REQ-021 Hsync=0 iff hcnt is in SYNC; Vsync=0 iff vcnt is in SYNC, for the whole of every line in that range.
REQ-022 While CE=0, every register SHALL hold its value.
REQ-023 Counter arithmetic SHALL be 12-bit unsigned; HTOTAL and VTOTAL above 4096 SHALL be rejected at elaboration.
REQ-024 Frame period SHALL be HTOTAL*VTOTAL CE cycles (420000 at defaults) with no drift.

Reset
REQ-025 While RESET_N=0: hcnt=vcnt=0, Hsync=1, Vsync=1, DE=0, hpos=vpos=0, frame_start=0.
REQ-026 Assertion mid-frame SHALL abort the frame immediately.
REQ-027 After deassertion, the first CE SHALL present hcnt=vcnt=0: DE=1, frame_start=1.

Configuration
REQ-028 With VGA_SYNC_GEN_TESTPAT_EN defined, output RGB[15:0] (565) SHALL be added, registered alongside DE.
REQ-029 RGB SHALL show 8 vertical colour bars of width HSIZE/8 (white, yellow, cyan, green, magenta, red, blue, black), and SHALL be 0 when DE=0.
REQ-030 Without the macro, the RGB port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package vga_timing_pkg SHALL hold the 640x480@60 timing constants and the phase enumeration (ACTIVE, FRONT, SYNC, BACK).
REQ-032 Sub-module vga_axis_counter (count, wrap pulse, phase decode) SHALL be instantiated twice, once horizontal and once vertical.

Verification
REQ-033 Reset held, CE=1 -> Hsync=1, Vsync=1, DE=0, hpos=vpos=0, frame_start=0.
REQ-034 Release reset, CE=1 -> DE=1 for 640 cycles; Hsync low for cycles 656..751 of each 800-cycle line.
REQ-035 Run a full frame -> Vsync low for exactly lines 490..491 (1600 cycles); frame_start pulses recur every 420000 cycles.
REQ-036 CE toggled 1/0 -> all timings double in CLK cycles; outputs stable on CE=0 cycles.
REQ-037 Reset asserted at line 200, column 300 -> outputs take reset values asynchronously; after release, frame_start=1 on the first CE.
REQ-038 Parameters HSIZE=8, HFP=HSW=HBP=1, VSIZE=4, VFP=VSW=VBP=1 -> 11-cycle lines and 77-cycle frames; hpos sequence 0..7 with DE=1.
